king_escape_scanner: RTL and testbench



---
 rtl/chess_pkg.sv | 34 +++
 rtl/king_neighbour_gen.sv | 22 ++
 rtl/king_escape_scanner.sv | 133 +++++++++++++
 tb/tb_king_escape_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared chess constants, status codes and king direction offsets
package chess_pkg;

   localparam int SQ_W       = 6;
   localparam int BOARD_W    = 256;
   localparam int COLOUR_BIT = 3;

   localparam logic [2:0] PIECE_EMPTY  = 3'd0;
   localparam logic [2:0] PIECE_PAWN   = 3'd1;
   localparam logic [2:0] PIECE_KNIGHT = 3'd2;
   localparam logic [2:0] PIECE_BISHOP = 3'd3;
   localparam logic [2:0] PIECE_ROOK   = 3'd4;
   localparam logic [2:0] PIECE_QUEEN  = 3'd5;
   localparam logic [2:0] PIECE_KING   = 3'd6;

   typedef enum logic [1:0] {
      STATUS_SAFE           = 2'b00,
      STATUS_CHECK          = 2'b01,
      STATUS_CHECKMATE      = 2'b10,
      STATUS_STALEMATE_CAND = 2'b11
   } status_t;

   // Direction d: row/col offsets, row 0 at the top of the board.
   localparam int DIR_ROW [8] = '{-1, -1, -1,  0,  0,  1,  1,  1};
   localparam int DIR_COL [8] = '{-1,  0,  1, -1,  1, -1,  0,  1};

   function automatic status_t statusOf(input logic inCheck, input logic anyEscape);
      if (inCheck)
         return anyEscape ? STATUS_CHECK : STATUS_CHECKMATE;
      else
         return anyEscape ? STATUS_SAFE : STATUS_STALEMATE_CAND;
   endfunction

endpackage

// File: rtl/king_neighbour_gen.sv
// rtl/king_neighbour_gen.sv - neighbour square of a king square in one of eight directions
module king_neighbour_gen
   import chess_pkg::*;
(
   input  logic [SQ_W-1:0] square,
   input  logic [2:0]      dir,
   output logic [SQ_W-1:0] neighbour,
   output logic            onBoard
);

   logic signed [4:0] rowN;
   logic signed [4:0] colN;

   always_comb begin
      rowN      = $signed({2'b00, square[5:3]}) + 5'(DIR_ROW[dir]);
      colN      = $signed({2'b00, square[2:0]}) + 5'(DIR_COL[dir]);
      // In-range coordinates 0..7 are exactly those with the top two bits clear.
      onBoard   = (rowN[4:3] == 2'b00) && (colN[4:3] == 2'b00);
      neighbour = {rowN[2:0], colN[2:0]};
   end

endmodule

// File: rtl/king_escape_scanner.sv
// rtl/king_escape_scanner.sv - sequential king safety scan over one shared legality/attack responder
module king_escape_scanner
   import chess_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               side,
   input  logic [SQ_W-1:0]    king_sq,
   input  logic [BOARD_W-1:0] board,
   output logic               query_valid,
   output logic [SQ_W-1:0]    query_sq,
   output logic [SQ_W-1:0]    query_from,
   output logic               query_side,
   input  logic               resp_valid,
   input  logic               resp_legal,
   input  logic               resp_attacked,
   output logic               busy,
   output logic               done,
   output logic [7:0]         escape_mask,
   output logic               in_check,
   output logic [1:0]         status
);

   typedef enum logic [2:0] {IDLE, QSELF, SCAN, QUERY, DONE} state_t;

   state_t             state;
   state_t             stateNext;
   logic [BOARD_W-1:0] boardQ;
   logic [2:0]         dirQ;
   logic [SQ_W-1:0]    neighbourSq;
   logic               onBoard;
   logic [3:0]         neighbourPiece;
   logic               prune;
   logic               lastDir;
   logic [7:0]         maskUpd;

   king_neighbour_gen neighbourGen (
      .square    (query_from),
      .dir       (dirQ),
      .neighbour (neighbourSq),
      .onBoard   (onBoard)
   );

   always_comb begin
      neighbourPiece = boardQ[{neighbourSq, 2'b00} +: 4];
      prune   = !onBoard || ((neighbourPiece[2:0] != PIECE_EMPTY) &&
                             (neighbourPiece[COLOUR_BIT] == query_side));
      lastDir = (dirQ == 3'd7);
      maskUpd = escape_mask;
      maskUpd[dirQ] = (state == QUERY) ? (resp_legal & ~resp_attacked) : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:  if (start) stateNext = QSELF;
         QSELF: if (resp_valid) stateNext = SCAN;
         SCAN: begin
            if (!prune)
               stateNext = QUERY;
            else if (lastDir)
               stateNext = DONE;
         end
         QUERY: if (resp_valid) stateNext = lastDir ? DONE : SCAN;
         DONE:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      query_valid = (state == QSELF) || (state == QUERY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         boardQ      <= '0;
         dirQ        <= '0;
         query_sq    <= '0;
         query_from  <= '0;
         query_side  <= 1'b0;
         escape_mask <= '0;
         in_check    <= 1'b0;
         status      <= STATUS_SAFE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  boardQ      <= board;
                  query_from  <= king_sq;
                  query_side  <= side;
                  query_sq    <= king_sq;
                  escape_mask <= '0;
                  dirQ        <= '0;
               end
            end
            QSELF: begin
               if (resp_valid)
                  in_check <= resp_attacked;
            end
            SCAN: begin
               if (prune) begin
                  escape_mask <= maskUpd;
                  dirQ        <= dirQ + 3'd1;
                  if (lastDir)
                     status <= statusOf(in_check, |maskUpd);
               end else begin
                  query_sq <= neighbourSq;
               end
            end
            QUERY: begin
               if (resp_valid) begin
                  escape_mask <= maskUpd;
                  dirQ        <= dirQ + 3'd1;
                  if (lastDir)
                     status <= statusOf(in_check, |maskUpd);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_king_escape_scanner.sv
// tb/tb_king_escape_scanner.sv - directed and randomized bench for king_escape_scanner
module tb_king_escape_scanner;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         side;
   logic [5:0]   king_sq;
   logic [255:0] board;
   logic         query_valid;
   logic [5:0]   query_sq;
   logic [5:0]   query_from;
   logic         query_side;
   logic         resp_valid;
   logic         resp_legal;
   logic         resp_attacked;
   logic         busy;
   logic         done;
   logic [7:0]   escape_mask;
   logic         in_check;
   logic [1:0]   status;

   int passCount = 0;
   int checkCount = 0;
   int failCount = 0;

   bit attackedMap [64];
   bit legalMap [64];
   int delayMode;
   int expQ [$];
   logic [7:0] expMask;
   logic       expCheck;
   logic [1:0] expStatus;

   king_escape_scanner dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .side          (side),
      .king_sq       (king_sq),
      .board         (board),
      .query_valid   (query_valid),
      .query_sq      (query_sq),
      .query_from    (query_from),
      .query_side    (query_side),
      .resp_valid    (resp_valid),
      .resp_legal    (resp_legal),
      .resp_attacked (resp_attacked),
      .busy          (busy),
      .done          (done),
      .escape_mask   (escape_mask),
      .in_check      (in_check),
      .status        (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setMaps(input int legalKind, input int attackKind);
      for (int i = 0; i < 64; i++) begin
         legalMap[i]    = (legalKind < 0) ? bit'($urandom_range(0, 1)) : bit'(legalKind);
         attackedMap[i] = (attackKind < 0) ? bit'($urandom_range(0, 1)) : bit'(attackKind);
      end
   endtask

   task automatic buildModel(input int kingSq, input logic sd, input logic [255:0] brd);
      int dr [8];
      int dc [8];
      int r;
      int c;
      int n;
      logic [3:0] p;
      bit anyEsc;
      dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
      dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
      expQ.delete();
      expQ.push_back(kingSq);
      expMask = 8'h00;
      for (int d = 0; d < 8; d++) begin
         r = kingSq / 8 + dr[d];
         c = kingSq % 8 + dc[d];
         if (r < 0 || r > 7 || c < 0 || c > 7) continue;
         n = r * 8 + c;
         p = brd[n*4 +: 4];
         if (p[2:0] != 3'd0 && p[3] == sd) continue;
         expQ.push_back(n);
         expMask[d] = legalMap[n] && !attackedMap[n];
      end
      expCheck = attackedMap[kingSq];
      anyEsc = (expMask != 8'h00);
      if (expCheck && anyEsc)        expStatus = 2'b01;
      else if (expCheck)             expStatus = 2'b10;
      else if (!anyEsc)              expStatus = 2'b11;
      else                           expStatus = 2'b00;
   endtask

   task automatic runScan(input int kingSq, input logic sd, input logic [255:0] brd, input bit midStart);
      int cycle;
      int qIdx;
      int waitLeft;
      int sumDelay;
      int curSq;
      bit pending;
      bit doneSeen;
      buildModel(kingSq, sd, brd);
      @(posedge clk); #1;
      king_sq = 6'(kingSq);
      side    = sd;
      board   = brd;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      board   = {8{$urandom}};
      king_sq = 6'($urandom_range(0, 63));
      side    = ~sd;
      cycle = 1; qIdx = 0; waitLeft = 0; sumDelay = 0; curSq = 0;
      pending = 0; doneSeen = 0;
      while (!doneSeen && cycle < 400) begin
         if (done) begin
            doneSeen = 1;
            check("done_cycle", cycle, 2 + 8 + (expQ.size() - 1) + sumDelay);
            check("escape_mask", escape_mask, expMask);
            check("in_check", in_check, expCheck);
            check("status", status, expStatus);
            check("busy_in_done", busy, 1'b1);
         end
         if (query_valid) begin
            if (!pending) begin
               check("query_sq", query_sq, (qIdx < expQ.size()) ? expQ[qIdx] : 32'hFFFF);
               check("query_from", query_from, kingSq);
               check("query_side", query_side, sd);
               curSq = int'(query_sq);
               pending = 1;
               waitLeft = (delayMode < 0) ? int'($urandom_range(0, 3)) : delayMode;
               sumDelay += waitLeft;
               qIdx++;
            end else begin
               check("query_stable", query_sq, curSq);
            end
            if (waitLeft == 0) begin
               resp_valid    = 1'b1;
               resp_legal    = legalMap[curSq];
               resp_attacked = attackedMap[curSq];
               pending = 0;
            end else begin
               resp_valid    = 1'b0;
               resp_legal    = 1'($urandom_range(0, 1));
               resp_attacked = 1'($urandom_range(0, 1));
               waitLeft--;
            end
         end else begin
            resp_valid    = doneSeen ? 1'b0 : 1'($urandom_range(0, 1));
            resp_legal    = 1'($urandom_range(0, 1));
            resp_attacked = 1'($urandom_range(0, 1));
         end
         start = (midStart && cycle == 5) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         cycle++;
      end
      resp_valid = 1'b0;
      start      = 1'b0;
      if (!doneSeen) check("done_timeout", 0, 1);
      check("query_count", qIdx, expQ.size());
      check("busy_after", busy, 1'b0);
      check("done_pulse", done, 1'b0);
      check("mask_hold", escape_mask, expMask);
      check("status_hold", status, expStatus);
   endtask

   initial begin
      logic [255:0] brd;
      int guard;
      reset = 1'b1; start = 1'b0; side = 1'b0; king_sq = '0; board = '0;
      resp_valid = 1'b0; resp_legal = 1'b0; resp_attacked = 1'b0;
      delayMode = 0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_qvalid", query_valid, 1'b0);
      check("rst_mask", escape_mask, 8'h00);
      check("rst_status", status, 2'b00);
      check("rst_qsq", query_sq, 6'd0);
      reset = 1'b0;

      setMaps(1, 0); delayMode = 0;
      runScan(36, 1'b0, '0, 1'b0);

      setMaps(-1, 1);
      runScan(0, 1'b0, '0, 1'b0);

      setMaps(-1, -1);
      runScan(7, 1'b0, '0, 1'b0);

      setMaps(1, 0);
      brd = '0;
      brd[54*4 +: 4] = 4'b0001;
      brd[55*4 +: 4] = 4'b0100;
      brd[62*4 +: 4] = 4'b0010;
      runScan(63, 1'b0, brd, 1'b0);

      setMaps(1, 0); delayMode = 3;
      runScan(36, 1'b0, '0, 1'b1);

      // Reset while the d3 neighbour (square 35) is being queried.
      setMaps(1, 0);
      @(posedge clk); #1;
      king_sq = 6'd36; side = 1'b0; board = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (!(query_valid && query_sq == 6'd35) && guard < 50) begin
         resp_valid = query_valid; resp_legal = 1'b1; resp_attacked = 1'b0;
         @(posedge clk); #1;
         guard++;
      end
      check("reach_d3", guard < 50, 1'b1);
      resp_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_qvalid", query_valid, 1'b0);
      check("midrst_mask", escape_mask, 8'h00);
      check("midrst_check", in_check, 1'b0);
      check("midrst_status", status, 2'b00);
      check("midrst_qsq", query_sq, 6'd0);
      check("midrst_qfrom", query_from, 6'd0);
      delayMode = 0;
      runScan(36, 1'b0, '0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         for (int s = 0; s < 64; s++)
            brd[s*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         setMaps(-1, -1);
         delayMode = -1;
         runScan(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), brd, bit'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
